// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Multi-cycle word load/store responder for the pipeline MEM stage. A request
//   raises memHAZ combinationally and keeps it high for LATENCY cycles while the
//   EX/MEM register stalls. The access happens on the edge into DONE. During
//   DONE, ReadData and memErr are valid and memHAZ is low, so the initiator
//   advances.
//   Storage is a byte array in big-endian order: mem[A] holds bits [31:24].
//
//   Ports
//     Clk        system clock, rising edge
//     Rst        asynchronous, active-high reset
//     memRead    load request
//     memWrite   store request (a store wins when both requests are high)
//     Address    byte address
//     WriteData  store data
//     ReadData   registered load data, holds its last loaded value
//     memHAZ     combinational busy/stall
//     memErr     registered fault flag, valid in DONE only
//
//   state  | meaning
//   IDLE   | waiting for a request; memHAZ follows memRead|memWrite
//   WAIT   | stall cycles, counting down; inputs ignored
//   DONE   | one cycle; results valid, memHAZ low, inputs ignored
module data_mem_responder #(
  parameter int DEPTH_BYTES = 256,
  parameter int LATENCY     = 2
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        memHAZ,
  output logic        memErr
);

  localparam int          AW       = $clog2(DEPTH_BYTES);
  localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);
  localparam logic [31:0] DEPTH_W  = 32'(DEPTH_BYTES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        op_rd_q, op_rd_d;
  logic        op_wr_q, op_wr_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [7:0]  mem_q [DEPTH_BYTES];
  logic [7:0]  mem_d [DEPTH_BYTES];

  logic          req;
  logic          enter_done;
  logic [31:0]   acc_addr;
  logic [31:0]   acc_wdata;
  logic          acc_rd;
  logic          acc_wr;
  logic          acc_fault;
  logic [AW-1:0] b0, b1, b2, b3;

  assign req = memRead | memWrite;

  // State register
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      op_rd_q <= 1'b0;
      op_wr_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < DEPTH_BYTES; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      op_rd_q <= op_rd_d;
      op_wr_q <= op_wr_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      mem_q   <= mem_d;
    end
  end

  // Next-state logic. The request is latched on acceptance. enter_done marks
  // the edge where the access takes place.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    op_rd_d    = op_rd_q;
    op_wr_d    = op_wr_q;
    enter_done = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          addr_d  = Address;
          wdata_d = WriteData;
          op_rd_d = memRead;
          op_wr_d = memWrite;
          cnt_d   = CNT_LOAD;
          if (LATENCY == 1) begin
            state_d    = S_DONE;
            enter_done = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d    = S_DONE;
          enter_done = 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // With LATENCY==1 the access edge is also the accept edge. On that edge the
  // latches have not been loaded yet, so the live inputs stand in for them.
  always_comb begin
    if (state_q == S_IDLE) begin
      acc_addr  = Address;
      acc_wdata = WriteData;
      acc_rd    = memRead;
      acc_wr    = memWrite;
    end else begin
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_rd    = op_rd_q;
      acc_wr    = op_wr_q;
    end
  end

  // The range check uses the full 32-bit address, so high addresses never wrap
  // into the array.
  assign acc_fault = (acc_addr[1:0] != 2'b00) || (acc_addr >= DEPTH_W);
  assign b0 = {acc_addr[AW-1:2], 2'b00};
  assign b1 = {acc_addr[AW-1:2], 2'b01};
  assign b2 = {acc_addr[AW-1:2], 2'b10};
  assign b3 = {acc_addr[AW-1:2], 2'b11};

  // Access datapath
  always_comb begin
    mem_d   = mem_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    if (enter_done) begin
      err_d = acc_fault | (acc_rd & acc_wr);
      if (acc_wr) begin
        if (!acc_fault) begin
          mem_d[b0] = acc_wdata[31:24];
          mem_d[b1] = acc_wdata[23:16];
          mem_d[b2] = acc_wdata[15:8];
          mem_d[b3] = acc_wdata[7:0];
        end
      end else if (acc_rd) begin
        rdata_d = acc_fault ? 32'h0 : {mem_q[b0], mem_q[b1], mem_q[b2], mem_q[b3]};
      end
    end else if (state_q == S_DONE) begin
      err_d = 1'b0;
    end
  end

  // Outputs. memHAZ is held low while Rst is asserted, whatever the request inputs show.
  always_comb begin
    memHAZ   = !Rst && (((state_q == S_IDLE) && req) || (state_q == S_WAIT));
    ReadData = rdata_q;
    memErr   = err_q;
  end

endmodule
